div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  divide request, held high by the EXE stage until ready
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- annul  in  1  cancel request from pipeline flush or exception
- opdata1  in  32  dividend (rs); sampled with start
- opdata2  in  32  divisor (rt); sampled with start
- result  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- ready  out  1  result valid; one-cycle pulse
- busy  out  1  operation in progress (IDLE excluded)

REQ-002 Parameter: DIV_WIDTH, default 32, operand width. Only 32 is supported.

Function
REQ-003 The state machine SHALL have exactly four states: IDLE, ZERO, BUSY, DONE.
REQ-004 Transitions from IDLE:
- start=1, annul=0, opdata2==0 -> ZERO.
- start=1, annul=0, opdata2!=0 -> BUSY, with the step counter set to 0.
- Otherwise the block stays in IDLE.
REQ-005 Operands, signed_div and both sign bits SHALL be latched on the IDLE exit edge; later changes to the inputs SHALL be ignored.
REQ-006 Signed mode: latched operands SHALL be converted to magnitudes (two's complement negate if negative) before iteration.
REQ-007 BUSY SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit MSB-first.
REQ-008 After the 32nd BUSY cycle (counter==31), the block SHALL go to DONE.
REQ-009 In DONE, ready=1 for exactly one cycle; the next state is IDLE unconditionally, and start is ignored in DONE.
REQ-010 Latency: if start is first high in cycle 0, ready SHALL be high in cycle 33. A start re-sampled in IDLE after DONE begins a new operation.
REQ-011 ZERO (divide by zero) SHALL write result=64'h0, assert ready on the next cycle (cycle 1 after start), then return to IDLE. No trap is raised.
REQ-012 Sign fixup, applied when entering DONE:
- quotient is negated if signed_div and the operand signs differ;
- remainder is negated if signed_div and the dividend is negative.
REQ-013 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no exception).
REQ-014 annul=1 in ZERO or BUSY SHALL force IDLE on the next edge. Ready is not asserted, and result keeps its previous value.
REQ-015 annul=1 together with start=1 in IDLE: annul wins and the block stays in IDLE.
REQ-016 annul in DONE has no effect: ready still pulses.
REQ-017 result SHALL be registered, update only on entry to DONE or ZERO completion, and hold its value until the next completion.
REQ-018 busy SHALL be 1 in ZERO and BUSY and 0 in IDLE and DONE. The EXE stage stall equals start & ~ready.

Reset
REQ-019 With rst=1 at a clock edge, the next state SHALL be: state=IDLE, counter=0, result=64'h0, ready=0, busy=0, latched operands=0.
REQ-020 rst SHALL override annul and start. A reset mid-operation abandons the division with no ready pulse.

Structure
REQ-021 State encodings (IDLE/ZERO/BUSY/DONE) and the DIV_WIDTH default SHALL live in the shared defines header alongside the ALU control codes.
REQ-022 One sub-module, div_step, SHALL be a combinational restoring step:
- inputs: partial remainder and divisor;
- outputs: next partial remainder and quotient bit.
The FSM, counter and sign logic SHALL stay in div_sequencer.

Verification
REQ-023 Unsigned 100/7, start held from cycle 0 -> ready in cycle 33 only, result={32'd2, 32'd14}.
REQ-024 Signed -7/2 (0xFFFFFFF9 / 0x2) -> result={0xFFFFFFFF, 0xFFFFFFFD}. Signed 0x80000000/0xFFFFFFFF -> {0x0, 0x80000000}.
REQ-025 Divisor 0 (opdata1=5) -> ready in cycle 1, result=64'h0, busy high only in cycle 1.
REQ-026 Start 100/7, annul in cycle 10 -> no ready, result unchanged, IDLE in cycle 11. A new 9/4 start then gives {1, 2} 33 cycles later.
REQ-027 rst in cycle 20 of a BUSY operation -> all outputs 0 next cycle and no ready pulse. Changing opdata1/opdata2 during BUSY -> result reflects the latched operands only.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared divider definitions: FSM state encodings, default operand width and
// the ALU control codes that select the divider in the EXE stage.
package div_sequencer_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  localparam logic [7:0] ALU_OP_DIV  = 8'h1A;
  localparam logic [7:0] ALU_OP_DIVU = 8'h1B;

  function automatic logic is_div_op(input logic [7:0] aluop);
    return (aluop == ALU_OP_DIV) || (aluop == ALU_OP_DIVU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: trial-subtract the divisor from
// the shifted partial remainder and keep the difference only if it fits.
module div_step
  import div_sequencer_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic [DIV_WIDTH:0]   i_partial_rem,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic [DIV_WIDTH-1:0] o_next_rem,
  output logic                 o_q_bit
);

  logic [DIV_WIDTH:0] w_diff;

  // The partial remainder is always below twice the divisor, so the top bit
  // of the difference is a reliable borrow flag.
  assign w_diff     = i_partial_rem - {1'b0, i_divisor};
  assign o_q_bit    = ~w_diff[DIV_WIDTH];
  assign o_next_rem = o_q_bit ? w_diff[DIV_WIDTH-1:0] : i_partial_rem[DIV_WIDTH-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned divider for the EXE stage: latches operands on
// start, iterates one quotient bit per cycle and pulses ready with {rem, quot}.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   signed_div,
  input  logic                   annul,
  input  logic [DIV_WIDTH-1:0]   opdata1,
  input  logic [DIV_WIDTH-1:0]   opdata2,
  output logic [2*DIV_WIDTH-1:0] result,
  output logic                   ready,
  output logic                   busy
);

  localparam int CNT_W = $clog2(DIV_WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_WIDTH - 1);

  div_state_t             r_state;
  logic [CNT_W-1:0]       r_count;
  logic [DIV_WIDTH-1:0]   r_quot;
  logic [DIV_WIDTH-1:0]   r_rem;
  logic [DIV_WIDTH-1:0]   r_divisor;
  logic                   r_signed;
  logic                   r_sign_a;
  logic                   r_sign_b;
  logic [2*DIV_WIDTH-1:0] r_result;
  logic                   r_ready;
  logic                   r_busy;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [DIV_WIDTH-1:0] w_a_mag;
  logic [DIV_WIDTH-1:0] w_b_mag;
  logic [DIV_WIDTH:0]   w_partial;
  logic [DIV_WIDTH-1:0] w_next_rem;
  logic                 w_q_bit;
  logic [DIV_WIDTH-1:0] w_quot_next;
  logic [DIV_WIDTH-1:0] w_quot_fix;
  logic [DIV_WIDTH-1:0] w_rem_fix;

  assign w_a_neg = signed_div & opdata1[DIV_WIDTH-1];
  assign w_b_neg = signed_div & opdata2[DIV_WIDTH-1];
  assign w_a_mag = w_a_neg ? -opdata1 : opdata1;
  assign w_b_mag = w_b_neg ? -opdata2 : opdata2;

  // r_quot starts as the dividend magnitude and is shifted out MSB-first
  // while quotient bits are shifted in at the bottom.
  assign w_partial   = {r_rem, r_quot[DIV_WIDTH-1]};
  assign w_quot_next = {r_quot[DIV_WIDTH-2:0], w_q_bit};

  div_step #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div_step (
    .i_partial_rem(w_partial),
    .i_divisor    (r_divisor),
    .o_next_rem   (w_next_rem),
    .o_q_bit      (w_q_bit)
  );

  assign w_quot_fix = (r_signed & (r_sign_a ^ r_sign_b)) ? -w_quot_next : w_quot_next;
  assign w_rem_fix  = (r_signed & r_sign_a) ? -w_next_rem : w_next_rem;

  // NOTE: all state here is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (start && !annul) begin
            r_quot    <= w_a_mag;
            r_divisor <= w_b_mag;
            r_rem     <= '0;
            r_count   <= '0;
            r_signed  <= signed_div;
            r_sign_a  <= opdata1[DIV_WIDTH-1];
            r_sign_b  <= opdata2[DIV_WIDTH-1];
            r_busy    <= 1'b1;
            if (opdata2 == '0) begin
              // Divide by zero completes immediately with a zero result.
              r_state  <= S_ZERO;
              r_result <= '0;
              r_ready  <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end

        S_ZERO: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end

        S_BUSY: begin
          if (annul) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_rem   <= w_next_rem;
            r_quot  <= w_quot_next;
            r_count <= r_count + 1'b1;
            if (r_count == LAST_STEP) begin
              r_state  <= S_DONE;
              r_result <= {w_rem_fix, w_quot_fix};
              r_ready  <= 1'b1;
              r_busy   <= 1'b0;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign ready  = r_ready;
  assign busy   = r_busy;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected results come from a behavioural
// divide model, are queued at start and popped when ready pulses.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_result = '0;

  div_sequencer #(.DIV_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .annul     (annul),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .result    (result),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) return 64'h0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start held from cycle 0 until ready; checks busy every cycle, ready latency,
  // the queued result, and that ready is a single-cycle pulse.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input bit scramble, input string name);
    int          exp_lat;
    int          seen;
    logic        exp_busy;
    logic [63:0] exp_res;
    exp_lat = (b == 32'h0) ? 1 : 33;
    seen    = 0;
    exp_q.push_back(model(a, b, sgn));
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      next_cycle();
      if (scramble && c == 3) begin
        opdata1    = ~a;
        opdata2    = b ^ 32'h0000_0005;
        signed_div = ~sgn;
      end
      exp_busy = (exp_lat == 1) ? (c == 1) : (c < exp_lat);
      n_checks++;
      if (busy !== exp_busy) begin
        n_errors++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, exp_busy);
      end
      if (ready === 1'b1) begin
        seen = c;
        n_checks++;
        if (c != exp_lat) begin
          n_errors++;
          $display("FAIL %s latency: got %0d expected %0d", name, c, exp_lat);
        end
        exp_res = exp_q.pop_front();
        n_checks++;
        if (result !== exp_res) begin
          n_errors++;
          $display("FAIL %s result: got %h expected %h", name, result, exp_res);
        end
        last_result = exp_res;
      end
    end
    if (seen == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: ready never seen, expected at cycle %0d", name, exp_lat);
      void'(exp_q.pop_front());
    end
    start = 1'b0;
    next_cycle();
    n_checks++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s after ready: ready=%b busy=%b expected 0/0", name, ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) next_cycle();
    n_checks++;
    if (result !== 64'h0 || ready !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: result=%h ready=%b busy=%b expected 0/0/0", result, ready, busy);
    end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_unsigned();
    do_div(32'd100, 32'd7, 1'b0, 1'b0, "udiv_100_7");
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "udiv_max_1");
    do_div(32'd3, 32'd10, 1'b0, 1'b0, "udiv_small");
  endtask

  task automatic test_signed();
    do_div(32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0, "sdiv_m7_2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "sdiv_wrap");
    do_div(32'd20, 32'hFFFF_FFFA, 1'b1, 1'b0, "sdiv_20_m6");
    do_div(32'hFFFF_FFEC, 32'hFFFF_FFFA, 1'b1, 1'b0, "sdiv_m20_m6");
  endtask

  task automatic test_div_zero();
    do_div(32'd5, 32'd0, 1'b0, 1'b0, "div_zero");
  endtask

  task automatic test_annul();
    logic [63:0] held;
    int          n_ready;
    held       = last_result;
    n_ready    = 0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    signed_div = 1'b0;
    start      = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (ready === 1'b1) n_ready++;
    end
    annul = 1'b1;
    start = 1'b0;
    next_cycle();
    annul = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_errors++;
      $display("FAIL annul idle: busy=%b ready=%b expected 0/0", busy, ready);
    end
    for (int c = 0; c < 35; c++) begin
      if (ready === 1'b1) n_ready++;
      next_cycle();
    end
    n_checks++;
    if (n_ready != 0) begin
      n_errors++;
      $display("FAIL annul ready: got %0d pulses expected 0", n_ready);
    end
    n_checks++;
    if (result !== held) begin
      n_errors++;
      $display("FAIL annul result: got %h expected %h", result, held);
    end
    do_div(32'd9, 32'd4, 1'b0, 1'b0, "after_annul_9_4");
  endtask

  task automatic test_idle_annul();
    opdata1 = 32'd50;
    opdata2 = 32'd5;
    start   = 1'b1;
    annul   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      n_checks++;
      if (busy !== 1'b0 || ready !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_annul cycle %0d: busy=%b ready=%b expected 0/0", c, busy, ready);
      end
    end
    start = 1'b0;
    annul = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int n_ready;
    n_ready    = 0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    signed_div = 1'b0;
    start      = 1'b1;
    for (int c = 1; c <= 20; c++) next_cycle();
    rst   = 1'b1;
    start = 1'b0;
    next_cycle();
    n_checks++;
    if (result !== 64'h0 || ready !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid: result=%h ready=%b busy=%b expected 0/0/0", result, ready, busy);
    end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      if (ready === 1'b1) n_ready++;
    end
    n_checks++;
    if (n_ready != 0) begin
      n_errors++;
      $display("FAIL reset_mid ready: got %0d pulses expected 0", n_ready);
    end
    last_result = 64'h0;
  endtask

  task automatic test_operand_change();
    do_div(32'd1000, 32'd33, 1'b0, 1'b1, "scramble_u");
    do_div(32'hFFFF_FC18, 32'd33, 1'b1, 1'b1, "scramble_s");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : $urandom_range(1, 300);
      s = $urandom_range(0, 1) == 1;
      do_div(a, b, s, 1'b0, "random");
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_idle_annul();
    test_reset_mid();
    test_operand_change();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
